// File: rtl/spi_reg_bank.sv
// SPI-side configuration register bank for the STFT core: 62 general words, CTRL (start/soft-reset)
// and STAT (busy/done). Optional macro SPI_REG_WR_PROTECT_EN drops general writes while the core is busy.
module spi_reg_bank #(
  parameter int               AW        = 6,
  parameter int               DW        = 28,
  parameter logic [AW-1:0]    CTRL_ADDR = 6'h3F,
  parameter logic [AW-1:0]    STAT_ADDR = 6'h3E
) (
  input  logic          SCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic [AW-1:0] iADDR,
  input  logic          iWr_EN,
  input  logic [DW-1:0] iWDATA,
  input  logic          iRd_EN,
  output logic [DW-1:0] oRDATA,
  output logic          oRd_VALID,
  input  logic [AW-1:0] iCORE_ADDR,
  output logic [DW-1:0] oCORE_DATA,
  input  logic          iCORE_BUSY,
  input  logic          iCORE_DONE,
  output logic          oSTART,
  output logic          oSOFT_RST,
  output logic          oWr_ERR
);

  localparam int NGEN = (1 << AW) - 2;

  logic [DW-1:0] gen_q [0:NGEN-1];
  logic [DW-3:0] ctrl_q;
  logic          done_sticky;

  logic [DW-1:0] ctrl_word;
  logic [DW-1:0] stat_word;

  logic          is_ctrl;
  logic          is_stat;
  logic          is_gen;
  logic          gen_blocked;
  logic          gen_we_p0;
  logic          ctrl_we_p0;
  logic          start_p0;
  logic          soft_p0;
  logic          err_p0;
  logic          stat_clr_p0;
  logic [DW-1:0] rd_mux_p0;

  assign ctrl_word = {ctrl_q, 2'b00};
  assign stat_word = {{(DW-2){1'b0}}, done_sticky, iCORE_BUSY};

  assign is_ctrl = (iADDR == CTRL_ADDR);
  assign is_stat = (iADDR == STAT_ADDR);
  assign is_gen  = (int'(iADDR) < NGEN);

  // Decode stage: everything below is evaluated on the pre-edge bank contents,
  // so a same-cycle read of a written address sees the old word.
  always_comb begin
    rd_mux_p0 = '0;
    if (is_stat) begin
      rd_mux_p0 = stat_word;
    end else if (is_ctrl) begin
      rd_mux_p0 = ctrl_word;
    end else if (is_gen) begin
      rd_mux_p0 = gen_q[iADDR];
    end
  end

  always_comb begin
    oCORE_DATA = '0;
    if (iCORE_ADDR == STAT_ADDR) begin
      oCORE_DATA = stat_word;
    end else if (iCORE_ADDR == CTRL_ADDR) begin
      oCORE_DATA = ctrl_word;
    end else if (int'(iCORE_ADDR) < NGEN) begin
      oCORE_DATA = gen_q[iCORE_ADDR];
    end
  end

`ifdef SPI_REG_WR_PROTECT_EN
  assign gen_blocked = iWr_EN & is_gen & iCORE_BUSY;
`else
  assign gen_blocked = 1'b0;
`endif

  assign gen_we_p0   = iWr_EN & is_gen & ~gen_blocked;
  assign ctrl_we_p0  = iWr_EN & is_ctrl;
  assign start_p0    = ctrl_we_p0 & iWDATA[0] & ~iCORE_BUSY;
  assign soft_p0     = ctrl_we_p0 & iWDATA[1];
  assign err_p0      = (ctrl_we_p0 & iWDATA[0] & iCORE_BUSY)
                     | (iWr_EN & is_stat)
                     | gen_blocked;
  assign stat_clr_p0 = iRd_EN & is_stat;

  // Storage stage: one register per general word, written on its own address match.
  for (genvar g = 0; g < NGEN; g++) begin : g_gen
    always_ff @(posedge SCLK or negedge iRSTn) begin
      if (!iRSTn) begin
        gen_q[g] <= '0;
      end else if (iCLR) begin
        gen_q[g] <= '0;
      end else if (gen_we_p0 && (int'(iADDR) == g)) begin
        gen_q[g] <= iWDATA;
      end
    end
  end

  always_ff @(posedge SCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      ctrl_q <= '0;
    end else if (iCLR) begin
      ctrl_q <= '0;
    end else if (ctrl_we_p0) begin
      ctrl_q <= iWDATA[DW-1:2];
    end
  end

  // A done pulse arriving on the clearing read wins, so the event is never lost.
  always_ff @(posedge SCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      done_sticky <= 1'b0;
    end else if (iCLR) begin
      done_sticky <= 1'b0;
    end else if (iCORE_DONE) begin
      done_sticky <= 1'b1;
    end else if (stat_clr_p0) begin
      done_sticky <= 1'b0;
    end
  end

  // Output stage: read data holds between reads; pulses last one cycle.
  always_ff @(posedge SCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oRDATA    <= '0;
      oRd_VALID <= 1'b0;
      oSTART    <= 1'b0;
      oSOFT_RST <= 1'b0;
      oWr_ERR   <= 1'b0;
    end else if (iCLR) begin
      oRDATA    <= '0;
      oRd_VALID <= 1'b0;
      oSTART    <= 1'b0;
      oSOFT_RST <= 1'b0;
      oWr_ERR   <= 1'b0;
    end else begin
      if (iRd_EN) begin
        oRDATA <= rd_mux_p0;
      end
      oRd_VALID <= iRd_EN;
      oSTART    <= start_p0;
      oSOFT_RST <= soft_p0;
      oWr_ERR   <= err_p0;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed vector table, hand sequences for clear/reset abort,
// then randomized traffic against an address-map reference model.
module tb_spi_reg_bank;

  localparam int         AW   = 6;
  localparam int         DW   = 28;
  localparam logic [5:0] CTRL = 6'h3F;
  localparam logic [5:0] STAT = 6'h3E;

  logic          SCLK = 1'b0;
  logic          iRSTn;
  logic          iCLR;
  logic [AW-1:0] iADDR;
  logic          iWr_EN;
  logic [DW-1:0] iWDATA;
  logic          iRd_EN;
  logic [DW-1:0] oRDATA;
  logic          oRd_VALID;
  logic [AW-1:0] iCORE_ADDR;
  logic [DW-1:0] oCORE_DATA;
  logic          iCORE_BUSY;
  logic          iCORE_DONE;
  logic          oSTART;
  logic          oSOFT_RST;
  logic          oWr_ERR;

  int total = 0;
  int bad   = 0;

  always #5 SCLK = ~SCLK;

  spi_reg_bank dut (
    .SCLK(SCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iADDR(iADDR), .iWr_EN(iWr_EN),
    .iWDATA(iWDATA), .iRd_EN(iRd_EN), .oRDATA(oRDATA), .oRd_VALID(oRd_VALID),
    .iCORE_ADDR(iCORE_ADDR), .oCORE_DATA(oCORE_DATA), .iCORE_BUSY(iCORE_BUSY),
    .iCORE_DONE(iCORE_DONE), .oSTART(oSTART), .oSOFT_RST(oSOFT_RST), .oWr_ERR(oWr_ERR)
  );

  // Reference model: the 64-entry address map as the software sees it.
  logic [DW-1:0] m_mem [0:63];
  logic          m_sticky;
  logic [DW-1:0] m_rdata;
  logic          m_vld, m_start, m_soft, m_err;

  function automatic logic [DW-1:0] m_view(input logic [5:0] a, input logic busy);
    if (a == STAT) return {26'd0, m_sticky, busy};
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_sticky = 0; m_rdata = '0; m_vld = 0; m_start = 0; m_soft = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] rv;
    rv = m_view(iADDR, iCORE_BUSY);
    if (iCLR) begin
      model_reset();
    end else begin
      m_vld = iRd_EN;
      if (iRd_EN) m_rdata = rv;
      m_start = 0; m_soft = 0; m_err = 0;
      if (iWr_EN) begin
        if (iADDR == STAT) begin
          m_err = 1;
        end else if (iADDR == CTRL) begin
          m_mem[63] = iWDATA & 28'hFFFFFFC;
          if (iWDATA[0]) begin
            if (iCORE_BUSY) m_err = 1;
            else            m_start = 1;
          end
          m_soft = iWDATA[1];
        end else begin
`ifdef SPI_REG_WR_PROTECT_EN
          if (iCORE_BUSY) m_err = 1;
          else            m_mem[iADDR] = iWDATA;
`else
          m_mem[iADDR] = iWDATA;
`endif
        end
      end
      if (iRd_EN && iADDR == STAT) m_sticky = 0;
      if (iCORE_DONE) m_sticky = 1;
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_model(input string nm, input int idx);
    chk({nm, ".rdata"}, idx, 32'(oRDATA), 32'(m_rdata));
    chk({nm, ".vld"},   idx, 32'(oRd_VALID), 32'(m_vld));
    chk({nm, ".start"}, idx, 32'(oSTART), 32'(m_start));
    chk({nm, ".soft"},  idx, 32'(oSOFT_RST), 32'(m_soft));
    chk({nm, ".err"},   idx, 32'(oWr_ERR), 32'(m_err));
    chk({nm, ".core"},  idx, 32'(oCORE_DATA), 32'(m_view(iCORE_ADDR, iCORE_BUSY)));
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [5:0] a, input logic [DW-1:0] wd,
                       input logic busy, input logic done, input logic [5:0] ca, input logic clr);
    iWr_EN = wr; iRd_EN = rd; iADDR = a; iWDATA = wd;
    iCORE_BUSY = busy; iCORE_DONE = done; iCORE_ADDR = ca; iCLR = clr;
  endtask

  task automatic tick();
    model_edge();
    @(posedge SCLK);
    #1;
  endtask

  typedef struct {
    logic          wr, rd;
    logic [5:0]    addr;
    logic [DW-1:0] wdata;
    logic          busy, done;
    logic [5:0]    caddr;
    logic [DW-1:0] e_rdata;
    logic          e_vld, e_start, e_soft, e_err;
    logic [DW-1:0] e_core;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic rd, input logic [5:0] a, input logic [DW-1:0] wd,
                     input logic busy, input logic done, input logic [5:0] ca,
                     input logic [DW-1:0] er, input logic ev, input logic es, input logic eso,
                     input logic ee, input logic [DW-1:0] ec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.busy = busy; v.done = done; v.caddr = ca;
    v.e_rdata = er; v.e_vld = ev; v.e_start = es; v.e_soft = eso; v.e_err = ee; v.e_core = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [DW-1:0] wp_err_core, wp_rd;
    logic          wp_err;
`ifdef SPI_REG_WR_PROTECT_EN
    wp_err = 1; wp_err_core = 28'h0; wp_rd = 28'h0;
`else
    wp_err = 0; wp_err_core = 28'h55; wp_rd = 28'h55;
`endif
    //   wr rd addr   wdata        bsy dn caddr  e_rdata     vld st sr er e_core
    add(1, 0, 6'h05, 28'h0ABCDEF, 0, 0, 6'h05, 28'h0,       0, 0, 0, 0, 28'h0ABCDEF);
    add(0, 1, 6'h05, 28'h0,       0, 0, 6'h05, 28'h0ABCDEF, 1, 0, 0, 0, 28'h0ABCDEF);
    add(0, 0, 6'h05, 28'h0,       0, 0, 6'h05, 28'h0ABCDEF, 0, 0, 0, 0, 28'h0ABCDEF);
    add(1, 0, CTRL,  28'h0000001, 0, 0, CTRL,  28'h0ABCDEF, 0, 1, 0, 0, 28'h0);
    add(0, 1, CTRL,  28'h0,       0, 0, CTRL,  28'h0,       1, 0, 0, 0, 28'h0);
    add(1, 0, CTRL,  28'h0000003, 1, 0, CTRL,  28'h0,       0, 0, 1, 1, 28'h0);
    add(0, 0, 6'h00, 28'h0,       0, 1, STAT,  28'h0,       0, 0, 0, 0, 28'h2);
    add(0, 1, STAT,  28'h0,       0, 0, STAT,  28'h2,       1, 0, 0, 0, 28'h0);
    add(0, 1, STAT,  28'h0,       0, 0, STAT,  28'h0,       1, 0, 0, 0, 28'h0);
    add(0, 1, STAT,  28'h0,       0, 1, STAT,  28'h0,       1, 0, 0, 0, 28'h2);
    add(0, 1, STAT,  28'h0,       0, 0, STAT,  28'h2,       1, 0, 0, 0, 28'h0);
    add(1, 0, 6'h10, 28'h0000007, 0, 0, 6'h10, 28'h2,       0, 0, 0, 0, 28'h7);
    add(1, 1, 6'h10, 28'h0000001, 0, 0, 6'h10, 28'h7,       1, 0, 0, 0, 28'h1);
    add(0, 1, 6'h10, 28'h0,       0, 0, 6'h10, 28'h1,       1, 0, 0, 0, 28'h1);
    add(1, 0, 6'h00, 28'h0000055, 1, 0, 6'h00, 28'h1,       0, 0, 0, wp_err, wp_err_core);
    add(0, 1, 6'h00, 28'h0,       0, 0, 6'h00, wp_rd,       1, 0, 0, 0, wp_rd);
    add(1, 0, STAT,  28'h0000123, 0, 0, STAT,  wp_rd,       0, 0, 0, 1, 28'h0);
    add(1, 0, CTRL,  28'hFFFFFFC, 0, 0, CTRL,  wp_rd,       0, 0, 0, 0, 28'hFFFFFFC);
    add(1, 1, CTRL,  28'h0000001, 1, 0, CTRL,  28'hFFFFFFC, 1, 0, 0, 1, 28'h0);

    drive(0, 0, 6'h05, '0, 0, 0, 6'h05, 0);
    iRSTn = 0;
    model_reset();
    repeat (2) @(posedge SCLK);
    #1;
    chk_model("reset", 0);
    chk("reset.rdata0", 0, 32'(oRDATA), 32'h0);
    iRSTn = 1;

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].busy, tbl[i].done, tbl[i].caddr, 0);
      tick();
      chk("vec.rdata", i, 32'(oRDATA), 32'(tbl[i].e_rdata));
      chk("vec.vld",   i, 32'(oRd_VALID), 32'(tbl[i].e_vld));
      chk("vec.start", i, 32'(oSTART), 32'(tbl[i].e_start));
      chk("vec.soft",  i, 32'(oSOFT_RST), 32'(tbl[i].e_soft));
      chk("vec.err",   i, 32'(oWr_ERR), 32'(tbl[i].e_err));
      chk("vec.core",  i, 32'(oCORE_DATA), 32'(tbl[i].e_core));
    end

    // Synchronous clear: arm the sticky bit, then clear over a CTRL write that would pulse.
    drive(1, 0, CTRL, 28'hFFFFFF0, 0, 1, CTRL, 0);
    tick();
    chk_model("clr_arm", 0);
    drive(1, 1, CTRL, 28'h0000003, 0, 0, CTRL, 1);
    tick();
    chk_model("clr", 0);
    chk("clr.soft0", 0, 32'(oSOFT_RST), 32'h0);
    begin
      logic [5:0] probe [4];
      probe[0] = 6'h05; probe[1] = 6'h10; probe[2] = CTRL; probe[3] = STAT;
      for (int k = 0; k < 4; k++) begin
        drive(0, 1, probe[k], '0, 0, 0, probe[k], 0);
        tick();
        chk_model("clr_rd", k);
        chk("clr_rd.zero", k, 32'(oRDATA), 32'h0);
      end
    end

    // Reset asserted mid-access aborts the write and the valid pulse.
    drive(1, 1, 6'h20, 28'h0000ABC, 0, 0, 6'h20, 0);
    #2 iRSTn = 0;
    model_reset();
    @(posedge SCLK);
    #1;
    chk_model("abort", 0);
    drive(0, 0, 6'h20, '0, 0, 0, 6'h20, 0);
    #2 iRSTn = 1;
    @(posedge SCLK);
    #1;
    drive(0, 1, 6'h20, '0, 0, 0, 6'h20, 0);
    tick();
    chk_model("abort_rd", 0);
    chk("abort_rd.vld", 0, 32'(oRd_VALID), 32'h1);

    for (int n = 0; n < 500; n++) begin
      logic [5:0] a, ca;
      int r;
      r = $urandom_range(0, 9);
      a = (r == 0) ? CTRL : (r == 1) ? STAT : (r == 2) ? 6'h3D : 6'($urandom_range(0, 63));
      r = $urandom_range(0, 5);
      ca = (r == 0) ? CTRL : (r == 1) ? STAT : a;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 28'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ca, ($urandom_range(0, 63) == 0));
      tick();
      chk_model("rand", n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
